// File: rtl/board_status_ctrl_if.sv
// Board status bus: microcontroller ready level, hasher and nonce strobes,
// LED display select, and the resulting LED / status outputs.
interface board_status_ctrl_if #(
  parameter int NUM_HASHERS = 3
);
  logic                   cclk;
  logic [NUM_HASHERS-1:0] hash_act;
  logic                   golden_nonce;
  logic [1:0]             mode;
  logic [7:0]             led;
  logic                   avr_ready;
  logic [15:0]            nonce_count;

  // Driver of the strobes and display select (board / testbench side)
  modport master (
    output cclk, hash_act, golden_nonce, mode,
    input  led, avr_ready, nonce_count
  );

  // The status controller itself
  modport slave (
    input  cclk, hash_act, golden_nonce, mode,
    output led, avr_ready, nonce_count
  );
endinterface

// File: rtl/board_status_ctrl.sv
// Board status controller: qualifies the microcontroller ready level,
// stretches hasher activity and golden-nonce strobes into visible LED
// pulses, counts golden nonces (saturating), runs a heartbeat and
// multiplexes everything onto a registered 8-bit LED bus.
module board_status_ctrl #(
  parameter int NUM_HASHERS      = 3,
  parameter int STRETCH_CYCLES   = 2500000,
  parameter int CCLK_STABLE      = 512,
  parameter int HEARTBEAT_CYCLES = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  board_status_ctrl_if.slave  bus
);

  localparam int SW = $clog2(STRETCH_CYCLES);
  localparam int CW = $clog2(CCLK_STABLE + 1);
  localparam int HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_MAX   = CW'(CCLK_STABLE);
  localparam logic [HW-1:0] HB_LAST      = HW'(HEARTBEAT_CYCLES - 1);

  // ---------------------------------------------------------------
  // cclk qualification
  // ---------------------------------------------------------------
  logic          sync1_q, sync2_q;
  logic [CW-1:0] stable_q, stable_d;
  logic          ready_q, ready_d;

  // Two-flop synchroniser for the asynchronous cclk level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.cclk;
      sync2_q <= sync1_q;
    end
  end

  // Saturating stable-high counter; ready only while the count is full
  always_comb begin
    stable_d = stable_q;
    ready_d  = sync2_q && (stable_q == STABLE_MAX);
    if (!sync2_q) begin
      stable_d = '0;
    end else if (stable_q != STABLE_MAX) begin
      stable_d = stable_q + 1'b1;
    end
  end

  // Qualification state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      ready_q  <= ready_d;
    end
  end

  // ---------------------------------------------------------------
  // Pulse stretchers: channels 0..NUM_HASHERS-1 are the hashers,
  // channel NUM_HASHERS is the golden-nonce flag.
  // ---------------------------------------------------------------
  logic [NUM_HASHERS:0] strobe_all;
  logic [NUM_HASHERS:0] act_all;

  assign strobe_all = {bus.golden_nonce, bus.hash_act};

  generate
    for (genvar gi = 0; gi <= NUM_HASHERS; gi++) begin : g_stretch
      logic [SW-1:0] timer_q, timer_d;
      logic          act_q;

      // Reload on strobe (also restarts a running hold), else count down
      always_comb begin
        timer_d = timer_q;
        if (strobe_all[gi]) begin
          timer_d = STRETCH_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end
      end

      // The strobe cycle itself covers the extra hold cycle the timer
      // cannot represent, giving exactly STRETCH_CYCLES of activity
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          timer_q <= '0;
          act_q   <= 1'b0;
        end else begin
          timer_q <= timer_d;
          act_q   <= strobe_all[gi] | (timer_q != '0);
        end
      end

      assign act_all[gi] = act_q;
    end
  endgenerate

  // ---------------------------------------------------------------
  // Golden nonce counter and heartbeat
  // ---------------------------------------------------------------
  logic [15:0]   count_q, count_d;
  logic [HW-1:0] hb_cnt_q, hb_cnt_d;
  logic          hb_q, hb_d;

  // Saturating nonce count and free-running heartbeat divider
  always_comb begin
    count_d  = count_q;
    hb_cnt_d = hb_cnt_q + 1'b1;
    hb_d     = hb_q;
    if (bus.golden_nonce && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  // Counter and heartbeat registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  // ---------------------------------------------------------------
  // LED multiplexer
  // ---------------------------------------------------------------
  logic [7:0] led_q, led_d;

  // Select the display source; a mode change shows on the next update
  always_comb begin
    led_d = '0;
    case (bus.mode)
      2'd0: begin
        led_d[7]               = hb_q;
        led_d[6]               = act_all[NUM_HASHERS];
        led_d[NUM_HASHERS-1:0] = act_all[NUM_HASHERS-1:0];
      end
      2'd1:    led_d = count_q[7:0];
      2'd2:    led_d = count_q[15:8];
      default: led_d = {ready_q, 6'b0, hb_q};
    endcase
  end

  // Registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign bus.led         = led_q;
  assign bus.avr_ready   = ready_q;
  assign bus.nonce_count = count_q;

endmodule

// File: tb/tb_board_status_ctrl.sv
// Directed testbench for board_status_ctrl with small parameters so the
// qualification, stretch and heartbeat timings can be checked per cycle.
module tb_board_status_ctrl;
  localparam int NH = 3;
  localparam int SC = 5;
  localparam int CS = 4;
  localparam int HB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  board_status_ctrl_if #(.NUM_HASHERS(NH)) bus ();

  board_status_ctrl #(
    .NUM_HASHERS     (NH),
    .STRETCH_CYCLES  (SC),
    .CCLK_STABLE     (CS),
    .HEARTBEAT_CYCLES(HB)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.cclk = 1'b0; bus.hash_act = '0; bus.golden_nonce = 1'b0; bus.mode = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", bus.led); end
    checks++; if (bus.avr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.avr_ready); end
    checks++; if (bus.nonce_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", bus.nonce_count); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL reset_release_led: got %h expected 00", bus.led); end
    $display("test_reset done");
  endtask

  task automatic test_cclk();
    logic exp;
    bus.cclk = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      exp = (k >= 7);
      checks++; if (bus.avr_ready !== exp) begin errors++; $display("FAIL cclk_qualify[%0d]: got %b expected %b", k, bus.avr_ready, exp); end
    end
    // one-cycle low glitch
    bus.cclk = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick(1);
      bus.cclk = 1'b1;
      exp = (j <= 2) || (j >= 8);
      checks++; if (bus.avr_ready !== exp) begin errors++; $display("FAIL cclk_glitch[%0d]: got %b expected %b", j, bus.avr_ready, exp); end
    end
    $display("test_cclk done");
  endtask

  task automatic test_stretch();
    logic [6:0] exp;
    bus.mode = 2'd0;
    tick(2);
    bus.hash_act = 3'b010;
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      bus.hash_act = '0;
      exp = (j >= 2 && j <= 6) ? 7'h02 : 7'h00;
      checks++; if (bus.led[6:0] !== exp) begin errors++; $display("FAIL stretch[%0d]: got %h expected %h", j, bus.led[6:0], exp); end
    end
    $display("test_stretch done");
  endtask

  task automatic test_retrigger();
    logic [6:0] exp;
    tick(3);
    bus.hash_act = 3'b010;
    for (int j = 1; j <= 11; j++) begin
      tick(1);
      bus.hash_act = (j == 3) ? 3'b010 : 3'b000;
      exp = (j >= 2 && j <= 9) ? 7'h02 : 7'h00;
      checks++; if (bus.led[6:0] !== exp) begin errors++; $display("FAIL retrigger[%0d]: got %h expected %h", j, bus.led[6:0], exp); end
    end
    $display("test_retrigger done");
  endtask

  task automatic test_all_hashers();
    bus.hash_act = 3'b111;
    tick(2);
    checks++; if (bus.led[6:0] !== 7'h07) begin errors++; $display("FAIL all_hashers_a: got %h expected 07", bus.led[6:0]); end
    tick(1);
    checks++; if (bus.led[6:0] !== 7'h07) begin errors++; $display("FAIL all_hashers_b: got %h expected 07", bus.led[6:0]); end
    bus.hash_act = '0;
    tick(10);
    checks++; if (bus.led[6:0] !== 7'h00) begin errors++; $display("FAIL all_hashers_idle: got %h expected 00", bus.led[6:0]); end
    $display("test_all_hashers done");
  endtask

  task automatic test_golden();
    logic exp;
    bus.golden_nonce = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick(1);
      bus.golden_nonce = 1'b0;
      exp = (j >= 2 && j <= 6);
      checks++; if (bus.led[6] !== exp) begin errors++; $display("FAIL golden_led[%0d]: got %b expected %b", j, bus.led[6], exp); end
    end
    bus.golden_nonce = 1'b1;
    tick(4);
    bus.golden_nonce = 1'b0;
    checks++; if (bus.nonce_count !== 16'd5) begin errors++; $display("FAIL golden_count: got %h expected 0005", bus.nonce_count); end
    bus.mode = 2'd1;
    tick(1);
    checks++; if (bus.led !== 8'h05) begin errors++; $display("FAIL mode1_low: got %h expected 05", bus.led); end
    bus.mode = 2'd2;
    tick(1);
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL mode2_high: got %h expected 00", bus.led); end
    bus.mode = 2'd0;
    tick(6);
    $display("test_golden done");
  endtask

  task automatic test_heartbeat();
    logic v;
    logic expb;
    bit   found;
    bus.mode = 2'd3;
    tick(1);
    v = bus.led[0];
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      tick(1);
      if (bus.led[0] !== v) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL heartbeat_edge: got no toggle expected toggle within 6 cycles"); end
    v = bus.led[0];
    for (int j = 1; j <= 6; j++) begin
      tick(1);
      expb = v ^ (((j / 3) % 2) == 1);
      checks++; if (bus.led !== {1'b1, 6'b0, expb}) begin errors++; $display("FAIL heartbeat[%0d]: got %h expected %h", j, bus.led, {1'b1, 6'b0, expb}); end
    end
    bus.cclk = 1'b0;
    tick(5);
    checks++; if (bus.led[7] !== 1'b0) begin errors++; $display("FAIL heartbeat_ready_low: got %b expected 0", bus.led[7]); end
    bus.cclk = 1'b1;
    tick(9);
    checks++; if (bus.led[7] !== 1'b1) begin errors++; $display("FAIL heartbeat_ready_high: got %b expected 1", bus.led[7]); end
    $display("test_heartbeat done");
  endtask

  task automatic test_reset_mid();
    bus.mode = 2'd1;
    bus.hash_act = 3'b001;
    tick(1);
    bus.hash_act = '0;
    tick(1);
    checks++; if (bus.led !== 8'h05) begin errors++; $display("FAIL pre_reset_led: got %h expected 05", bus.led); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.led !== 8'h00) begin errors++; $display("FAIL mid_reset_led: got %h expected 00", bus.led); end
    checks++; if (bus.avr_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0", bus.avr_ready); end
    checks++; if (bus.nonce_count !== 16'h0000) begin errors++; $display("FAIL mid_reset_count: got %h expected 0000", bus.nonce_count); end
    bus.cclk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      checks++; if ({bus.led, bus.avr_ready, bus.nonce_count} !== 25'd0) begin errors++; $display("FAIL post_reset[%0d]: got led=%h rdy=%b cnt=%h expected all 0", j, bus.led, bus.avr_ready, bus.nonce_count); end
    end
    bus.mode = 2'd0;
    tick(1);
    checks++; if (bus.led[6:0] !== 7'h00) begin errors++; $display("FAIL post_reset_stretch: got %h expected 00", bus.led[6:0]); end
    $display("test_reset_mid done");
  endtask

  task automatic test_saturate();
    bus.mode = 2'd1;
    bus.golden_nonce = 1'b1;
    tick(70000);
    bus.golden_nonce = 1'b0;
    tick(1);
    checks++; if (bus.nonce_count !== 16'hFFFF) begin errors++; $display("FAIL saturate_count: got %h expected FFFF", bus.nonce_count); end
    checks++; if (bus.led !== 8'hFF) begin errors++; $display("FAIL saturate_mode1: got %h expected FF", bus.led); end
    bus.mode = 2'd2;
    tick(1);
    checks++; if (bus.led !== 8'hFF) begin errors++; $display("FAIL saturate_mode2: got %h expected FF", bus.led); end
    bus.golden_nonce = 1'b1;
    tick(1);
    bus.golden_nonce = 1'b0;
    tick(1);
    checks++; if (bus.nonce_count !== 16'hFFFF) begin errors++; $display("FAIL saturate_nowrap: got %h expected FFFF", bus.nonce_count); end
    $display("test_saturate done");
  endtask

  task automatic test_back_to_back();
    bus.mode = 2'd1;
    tick(1);
    checks++; if (bus.led !== 8'hFF) begin errors++; $display("FAIL b2b_mode1: got %h expected FF", bus.led); end
    bus.mode = 2'd3;
    tick(1);
    checks++; if (bus.led[7:1] !== 7'h00) begin errors++; $display("FAIL b2b_mode3: got %h expected 00 in [7:1]", bus.led[7:1]); end
    bus.mode = 2'd2;
    tick(1);
    checks++; if (bus.led !== 8'hFF) begin errors++; $display("FAIL b2b_mode2: got %h expected FF", bus.led); end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_cclk();
    test_stretch();
    test_retrigger();
    test_all_hashers();
    test_golden();
    test_heartbeat();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_status_ctrl.md
BOARD_STATUS_CTRL -- requirements
Module: board_status_ctrl

Interface
REQ-001 SHALL have parameter NUM_HASHERS, default 3, number of hasher activity inputs, legal range 1..6.
REQ-002 SHALL have parameter STRETCH_CYCLES, default 2500000, LED hold time in clk cycles, minimum 2.
REQ-003 SHALL have parameter CCLK_STABLE, default 512, consecutive synchronised-high cclk cycles required before avr_ready, minimum 1.
REQ-004 SHALL have parameter HEARTBEAT_CYCLES, default 25000000, clk cycles per heartbeat toggle, minimum 1.
REQ-005 SHALL have port clk, input, 1, sole clock; all flops on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cclk, input, 1, asynchronous microcontroller-ready level.
REQ-008 SHALL have port hash_act, input, NUM_HASHERS, per-hasher activity strobe, synchronous to clk.
REQ-009 SHALL have port golden_nonce, input, 1, single-cycle nonce-found strobe.
REQ-010 SHALL have port mode, input, 2, LED display select, synchronous to clk.
REQ-011 SHALL have port led, output, 8, registered LED drive.
REQ-012 SHALL have port avr_ready, output, 1, high when the serial link may be driven.
REQ-013 SHALL have port nonce_count, output, 16, saturating count of golden nonces.

Function
REQ-014 SHALL pass cclk through a two-flop synchroniser before any use; avr_ready therefore lags a cclk rise by at least 2 cycles.
REQ-015 SHALL count consecutive cycles of synchronised cclk high, saturating at CCLK_STABLE; counter clears in the cycle synchronised cclk is low.
REQ-016 SHALL assert avr_ready registered in the cycle after the counter reaches CCLK_STABLE, and deassert it the cycle after synchronised cclk goes low, with no hysteresis.
REQ-017 SHALL give each hasher i its own stretch timer: hash_act[i] high loads STRETCH_CYCLES-1, otherwise a nonzero timer decrements; act[i] is timer nonzero or reload in progress.
REQ-018 SHALL hold act[i] high for exactly STRETCH_CYCLES cycles after an isolated single-cycle strobe, starting the cycle after the strobe.
REQ-019 SHALL restart the full hold period when a strobe arrives while the timer is running (retrigger), including the final-count cycle.
REQ-020 SHALL stretch golden_nonce identically into an internal golden flag with its own timer.
REQ-021 SHALL increment nonce_count by 1 per cycle with golden_nonce high, holding at 16'hFFFF with no wrap.
REQ-022 SHALL toggle a heartbeat flag every HEARTBEAT_CYCLES cycles using a free-running counter that wraps to 0 at the toggle.
REQ-023 SHALL register led with one cycle of latency from mode and from the internal flags, using mode 0: led[7]=heartbeat, led[6]=golden, led[5:0]=act zero-extended, with bits at and above NUM_HASHERS reading 0.
REQ-024 SHALL drive mode 1: led=nonce_count[7:0]; mode 2: led=nonce_count[15:8]; mode 3: led={avr_ready, 6'b0, heartbeat}.
REQ-025 SHALL apply a mode change on the next registered led update, with no blanking cycle.
REQ-026 SHALL count golden_nonce regardless of avr_ready; the count is not gated.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force led=0, avr_ready=0, nonce_count=0, all timers, counters, synchroniser flops and heartbeat to 0.
REQ-028 SHALL abort any in-progress stretch, cclk qualification or count on reset assertion mid-operation, with no residual state after release.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deassertion; the external environment guarantees synchronous deassertion.

Verification
REQ-030 SHALL be tested with CCLK_STABLE=4: cclk high from cycle 0 gives avr_ready=1 at cycle 7; a 1-cycle cclk low glitch gives avr_ready=0 two cycles later and requalification taking another 4 stable cycles.
REQ-031 SHALL be tested with STRETCH_CYCLES=5: a single hash_act[1] strobe gives led[1]=1 for exactly 5 consecutive led cycles in mode 0; a second strobe at hold cycle 3 extends the hold to 8 cycles total.
REQ-032 SHALL be tested with NUM_HASHERS=3: driving all hash_act high gives led[5:3]=0 and led[2:0]=3'b111.
REQ-033 SHALL be tested with golden_nonce held high for 70000 cycles: nonce_count=16'hFFFF, mode 1 gives led=8'hFF, mode 2 gives led=8'hFF.
REQ-034 SHALL be tested with HEARTBEAT_CYCLES=3 in mode 3: led[0] toggles every 3 cycles and led[7] tracks avr_ready.
REQ-035 SHALL be tested by asserting rst_n low mid-stretch with nonce_count=5: all outputs read 0 in the same cycle, before any clk edge, and stay 0 after release until new stimulus arrives.
